mpmc11_cmd_issue: RTL and testbench

//  Command-issue stage of the mpmc11 controller, driving the DDR app (MIG)

---
 rtl/mpmc11_cmd_issue_if.sv | 26 ++
 rtl/mpmc11_cmd_issue.sv | 94 +++++++++
 tb/tb_mpmc11_cmd_issue.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mpmc11_cmd_issue_if.sv
// Command-issue bundle between the mpmc11 channel FSM, the issue stage and the MIG app port.
// The master side is the requester/MIG environment; the slave side is the issue stage.
interface mpmc11_cmd_issue_if;
    logic        start;
    logic        we;
    logic [7:0]  burst_len;
    logic [31:0] addr_base;
    logic        wdat_valid;
    logic        app_rdy;
    logic        app_en;
    logic [2:0]  app_cmd;
    logic [31:0] app_addr;
    logic [7:0]  cmd_cnt;
    logic        busy;
    logic        done;

    modport master (
        output start, we, burst_len, addr_base, wdat_valid, app_rdy,
        input  app_en, app_cmd, app_addr, cmd_cnt, busy, done
    );

    modport slave (
        input  start, we, burst_len, addr_base, wdat_valid, app_rdy,
        output app_en, app_cmd, app_addr, cmd_cnt, busy, done
    );
endinterface

// File: rtl/mpmc11_cmd_issue.sv
// mpmc11 command-issue stage: latches a burst request and issues burst_len+1
// MIG commands at consecutive WID/8-byte addresses, then pulses done.
module mpmc11_cmd_issue #(
    parameter int WID = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    mpmc11_cmd_issue_if.slave    bus
);
    localparam int          INC      = WID / 8;
    localparam logic [31:0] INC_W    = 32'(INC);
    localparam logic [31:0] ALN_MASK = ~(INC_W - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  len_q, len_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        app_en_s;
    logic [31:0] addr_inc_s;

    // State and burst-context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            len_q   <= 8'd0;
            addr_q  <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; address bits [31:30] are cleared so the beat address wraps at 1 GiB.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        len_d      = len_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        app_en_s   = 1'b0;
        addr_inc_s = addr_q + INC_W;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    we_d    = bus.we;
                    len_d   = bus.burst_len;
                    addr_d  = {2'b00, bus.addr_base[29:0]} & ALN_MASK;
                    cnt_d   = 8'd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                app_en_s = !we_q || bus.wdat_valid;
                if (app_en_s && bus.app_rdy) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = {2'b00, addr_inc_s[29:0]};
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.app_en   = app_en_s;
    assign bus.app_cmd  = we_q ? 3'b000 : 3'b001;
    assign bus.app_addr = addr_q;
    assign bus.cmd_cnt  = cnt_q;
    assign bus.busy     = (state_q == ST_ISSUE);
    assign bus.done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_mpmc11_cmd_issue.sv
// Directed self-checking bench for mpmc11_cmd_issue with hand-computed expectations.
module tb_mpmc11_cmd_issue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mpmc11_cmd_issue_if bus();

    mpmc11_cmd_issue #(.WID(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observed output vector: {app_en, app_cmd, app_addr, cmd_cnt, busy, done}
    wire [45:0] obs = {bus.app_en, bus.app_cmd, bus.app_addr, bus.cmd_cnt, bus.busy, bus.done};

    function automatic logic [45:0] ex(input logic en, input logic [2:0] cmd, input logic [31:0] a,
                                       input logic [7:0] c, input logic b, input logic d);
        return {en, cmd, a, c, b, d};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.we         = 1'b0;
        bus.burst_len  = 8'd0;
        bus.addr_base  = 32'd0;
        bus.wdat_valid = 1'b0;
        bus.app_rdy    = 1'b0;
    endtask

    task automatic issue_start(input logic w, input logic [7:0] len, input logic [31:0] a);
        bus.start     = 1'b1;
        bus.we        = w;
        bus.burst_len = len;
        bus.addr_base = a;
        cyc();
        bus.start     = 1'b0;
        bus.we        = ~w;
        bus.burst_len = 8'hAA;
        bus.addr_base = 32'h1234_5678;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'd0, 8'd0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs, ex(1'b0, 3'b001, 32'd0, 8'd0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_read_burst();
        bus.app_rdy = 1'b1;
        issue_start(1'b0, 8'd3, 32'h1000_0013);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs !== ex(1'b1, 3'b001, 32'h1000_0000 + 32'(i * 32), 8'(i), 1'b1, 1'b0)) begin
                n_fail++; $display("FAIL read_beat%0d: got %h expected %h", i, obs,
                                   ex(1'b1, 3'b001, 32'h1000_0000 + 32'(i * 32), 8'(i), 1'b1, 1'b0));
            end
            cyc();
        end
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h1000_0060, 8'd3, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL read_done: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h1000_0060, 8'd3, 1'b0, 1'b1));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h1000_0060, 8'd3, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL read_idle: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h1000_0060, 8'd3, 1'b0, 1'b0));
        end
    endtask

    task automatic test_write_wdat_stall();
        bus.app_rdy    = 1'b1;
        bus.wdat_valid = 1'b0;
        issue_start(1'b1, 8'd1, 32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (obs !== ex(1'b0, 3'b000, 32'h0000_0200, 8'd0, 1'b1, 1'b0)) begin
                n_fail++; $display("FAIL write_wait%0d: got %h expected %h", i, obs, ex(1'b0, 3'b000, 32'h0000_0200, 8'd0, 1'b1, 1'b0));
            end
            cyc();
        end
        bus.wdat_valid = 1'b1;
        #1;
        n_checks++;
        if (obs !== ex(1'b1, 3'b000, 32'h0000_0200, 8'd0, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL write_beat0: got %h expected %h", obs, ex(1'b1, 3'b000, 32'h0000_0200, 8'd0, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b1, 3'b000, 32'h0000_0220, 8'd1, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL write_beat1: got %h expected %h", obs, ex(1'b1, 3'b000, 32'h0000_0220, 8'd1, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b000, 32'h0000_0220, 8'd1, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL write_done: got %h expected %h", obs, ex(1'b0, 3'b000, 32'h0000_0220, 8'd1, 1'b0, 1'b1));
        end
        bus.wdat_valid = 1'b0;
        cyc();
    endtask

    task automatic test_rdy_stall();
        logic [3:0] rdy_seq = 4'b1001;
        int         done_seen = 0;
        bus.app_rdy = 1'b1;
        issue_start(1'b0, 8'd1, 32'h0000_0400);
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h0000_0400, 8'd0, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL stall_beat0: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h0000_0400, 8'd0, 1'b1, 1'b0));
        end
        for (int i = 1; i < 4; i++) begin
            cyc();
            bus.app_rdy = rdy_seq[3 - i];
            #1;
            n_checks++;
            if (obs !== ex(1'b1, 3'b001, 32'h0000_0420, 8'd1, 1'b1, 1'b0)) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, ex(1'b1, 3'b001, 32'h0000_0420, 8'd1, 1'b1, 1'b0));
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.done === 1'b1) done_seen++;
        end
        n_checks++;
        if (done_seen !== 1) begin
            n_fail++; $display("FAIL stall_done_count: got %0d expected 1", done_seen);
        end
    endtask

    task automatic test_addr_wrap();
        bus.app_rdy = 1'b1;
        issue_start(1'b0, 8'd0, 32'hFFFF_FFE0);
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h3FFF_FFE0, 8'd0, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL wrap_single: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h3FFF_FFE0, 8'd0, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h3FFF_FFE0, 8'd0, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL wrap_single_done: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h3FFF_FFE0, 8'd0, 1'b0, 1'b1));
        end
        cyc();
        issue_start(1'b0, 8'd1, 32'hFFFF_FFE0);
        cyc();
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h0000_0000, 8'd1, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL wrap_second: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h0000_0000, 8'd1, 1'b1, 1'b0));
        end
        cyc(); cyc();
    endtask

    task automatic test_start_ignored();
        bus.app_rdy = 1'b1;
        issue_start(1'b0, 8'd2, 32'h0000_0800);
        bus.start     = 1'b1;
        bus.we        = 1'b1;
        bus.addr_base = 32'h0000_9000;
        cyc();
        bus.start = 1'b0;
        #1;
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h0000_0820, 8'd1, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL ign_beat1: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h0000_0820, 8'd1, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h0000_0840, 8'd2, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL ign_beat2: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h0000_0840, 8'd2, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL ign_done: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b1));
        end
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        #1;
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL ign_idle: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL ign_no_latch: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h0000_0840, 8'd2, 1'b0, 1'b0));
        end
    endtask

    task automatic test_reset_mid_burst();
        int bad = 0;
        bus.app_rdy = 1'b1;
        issue_start(1'b1, 8'd7, 32'h0000_0000);
        bus.wdat_valid = 1'b1;
        cyc(); cyc();
        n_checks++;
        if (obs !== ex(1'b1, 3'b000, 32'h0000_0040, 8'd2, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL rst_pre: got %h expected %h", obs, ex(1'b1, 3'b000, 32'h0000_0040, 8'd2, 1'b1, 1'b0));
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'd0, 8'd0, 1'b0, 1'b0)) begin
            n_fail++; $display("FAIL rst_mid: got %h expected %h", obs, ex(1'b0, 3'b001, 32'd0, 8'd0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (bus.done !== 1'b0 || bus.app_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rst_quiet: got %0d bad cycles expected 0", bad);
        end
        bus.wdat_valid = 1'b0;
        issue_start(1'b0, 8'd0, 32'h0000_0060);
        n_checks++;
        if (obs !== ex(1'b1, 3'b001, 32'h0000_0060, 8'd0, 1'b1, 1'b0)) begin
            n_fail++; $display("FAIL rst_restart: got %h expected %h", obs, ex(1'b1, 3'b001, 32'h0000_0060, 8'd0, 1'b1, 1'b0));
        end
        cyc();
        n_checks++;
        if (obs !== ex(1'b0, 3'b001, 32'h0000_0060, 8'd0, 1'b0, 1'b1)) begin
            n_fail++; $display("FAIL rst_restart_done: got %h expected %h", obs, ex(1'b0, 3'b001, 32'h0000_0060, 8'd0, 1'b0, 1'b1));
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_wdat_stall();
        test_rdy_stall();
        test_addr_wrap();
        test_start_ignored();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
